// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the 8N1 UART slice (uart_main / uart_rx):
//   - uart_state_e      : 4-state frame FSM encoding shared by TX and RX
//   - LINE_IDLE         : idle (mark) level of an RS-232 TTL line
//   - CNT_W / CNT_*     : width and constants of the per-bit clock counters
//   - calc_clks_per_bit : clocks per bit from clock frequency and baud rate
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic LINE_IDLE = 1'b1;

  // 16 bits covers any practical divider (434 at 50 MHz / 115200).
  localparam int               CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_ZERO = 16'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 16'd1;

  // Integer (truncating) divider; 50 MHz / 115200 gives 434.
  function automatic int calc_clks_per_bit(input int clk_freq_hz, input int baud);
    return clk_freq_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 receiver: 2-flop synchroniser, start-bit validation at half bit, mid-bit
// sampling of 8 data bits (LSB first) and stop-bit check.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   rxd       in   serial line, idle high, asynchronous to clk (an undriven
//                  line must be held high by the board pull-up)
//   rx_data   out  last byte received with a valid stop bit
//   rx_valid  out  one-clock pulse when rx_data has just been updated
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rxd_meta_r;
  logic             rxd_sync_r;
  uart_state_e      state_r,  state_nxt_s;
  logic [CNT_W-1:0] cnt_r,    cnt_nxt_s;
  logic [2:0]       idx_r,    idx_nxt_s;
  logic [7:0]       shift_r,  shift_nxt_s;
  logic [7:0]       data_r,   data_nxt_s;
  logic             valid_r,  valid_nxt_s;

  // Two-stage synchroniser; resets to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_r <= LINE_IDLE;
      rxd_sync_r <= LINE_IDLE;
    end else begin
      rxd_meta_r <= rxd;
      rxd_sync_r <= rxd_meta_r;
    end
  end

  // RX next-state logic: START is re-checked at half bit so that short low
  // glitches fall back to IDLE; from then on every sample is a full bit apart.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    shift_nxt_s = shift_r;
    data_nxt_s  = data_r;
    valid_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        if (rxd_sync_r == 1'b0) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_nxt_s = CNT_ZERO;
          idx_nxt_s = 3'd0;
          if (rxd_sync_r == 1'b0) begin
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_nxt_s   = CNT_ZERO;
          shift_nxt_s = {rxd_sync_r, shift_r[7:1]};
          if (idx_r == 3'd7) begin
            state_nxt_s = STOP;
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = IDLE;
          // A low stop bit is a framing error: the byte is dropped silently.
          if (rxd_sync_r == 1'b1) begin
            valid_nxt_s = 1'b1;
            data_nxt_s  = shift_r;
          end else begin
            valid_nxt_s = 1'b0;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // RX state, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      shift_r <= shift_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  assign rx_data  = data_r;
  assign rx_valid = valid_r;

endmodule

// File: rtl/uart_main.sv
// -----------------------------------------------------------------------------
// uart_main
// Top-level 8N1 UART for the USB-RS232 bridge, single user_clock domain.
// A 0->1 edge on send_trigger (while TX is idle) sends send_data; received
// bytes with a valid stop bit toggle gpio_led1.
// Ports:
//   user_clock     in   system clock (50 MHz nominal)
//   rst            in   asynchronous active-low reset
//   usb_rs232_rxd  in   serial receive line, idle high
//   send_trigger   in   transmit request, rising edge starts a frame
//   send_data      in   byte to transmit, latched on the trigger edge
//   usb_rs232_txd  out  serial transmit line, idle high
//   gpio_led1      out  toggles on every valid received byte
// Build option:
//   UART_ECHO_EN   when defined, each valid received byte is retransmitted if
//                  TX is idle in that cycle; a same-cycle trigger edge wins.
// -----------------------------------------------------------------------------
module uart_main
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200
) (
  input  logic       user_clock,
  input  logic       rst,
  input  logic       usb_rs232_rxd,
  input  logic       send_trigger,
  input  logic [7:0] send_data,
  output logic       usb_rs232_txd,
  output logic       gpio_led1
);

  localparam int               CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);

  logic             trig_r;
  logic             trig_prev_r;
  logic             edge_s;
  logic             echo_req_s;
  logic [7:0]       rx_data_s;
  logic             rx_valid_s;
  uart_state_e      tx_state_r, tx_state_nxt_s;
  logic [CNT_W-1:0] tx_cnt_r,   tx_cnt_nxt_s;
  logic [2:0]       tx_idx_r,   tx_idx_nxt_s;
  logic [7:0]       tx_shift_r, tx_shift_nxt_s;
  logic             txd_line_s;
  logic             txd_r;
  logic             led_r;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (user_clock),
    .rst_n    (rst),
    .rxd      (usb_rs232_rxd),
    .rx_data  (rx_data_s),
    .rx_valid (rx_valid_s)
  );

`ifdef UART_ECHO_EN
  assign echo_req_s = rx_valid_s;
`else
  assign echo_req_s = 1'b0;
`endif

  // Register the trigger once, then keep one more stage for edge detection.
  always_ff @(posedge user_clock or negedge rst) begin
    if (!rst) begin
      trig_r      <= 1'b0;
      trig_prev_r <= 1'b0;
    end else begin
      trig_r      <= send_trigger;
      trig_prev_r <= trig_r;
    end
  end

  assign edge_s = trig_r & ~trig_prev_r;

  // TX next-state logic; edges outside IDLE are dropped, not queued.
  always_comb begin
    tx_state_nxt_s = tx_state_r;
    tx_cnt_nxt_s   = tx_cnt_r;
    tx_idx_nxt_s   = tx_idx_r;
    tx_shift_nxt_s = tx_shift_r;
    case (tx_state_r)
      IDLE: begin
        tx_cnt_nxt_s = CNT_ZERO;
        tx_idx_nxt_s = 3'd0;
        if (edge_s) begin
          tx_state_nxt_s = START;
          tx_shift_nxt_s = send_data;
        end else if (echo_req_s) begin
          tx_state_nxt_s = START;
          tx_shift_nxt_s = rx_data_s;
        end else begin
          tx_state_nxt_s = IDLE;
        end
      end
      START: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_nxt_s   = CNT_ZERO;
          tx_idx_nxt_s   = 3'd0;
          tx_state_nxt_s = DATA;
        end else begin
          tx_cnt_nxt_s = tx_cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_nxt_s = CNT_ZERO;
          if (tx_idx_r == 3'd7) begin
            tx_state_nxt_s = STOP;
          end else begin
            tx_idx_nxt_s   = tx_idx_r + 3'd1;
            tx_shift_nxt_s = {1'b0, tx_shift_r[7:1]};
          end
        end else begin
          tx_cnt_nxt_s = tx_cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_nxt_s   = CNT_ZERO;
          tx_state_nxt_s = IDLE;
        end else begin
          tx_cnt_nxt_s = tx_cnt_r + CNT_ONE;
        end
      end
      default: begin
        tx_state_nxt_s = IDLE;
        tx_cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Line level for the current TX state; registered below so txd is glitch-free.
  always_comb begin
    txd_line_s = LINE_IDLE;
    case (tx_state_r)
      IDLE:    txd_line_s = LINE_IDLE;
      START:   txd_line_s = 1'b0;
      DATA:    txd_line_s = tx_shift_r[0];
      STOP:    txd_line_s = LINE_IDLE;
      default: txd_line_s = LINE_IDLE;
    endcase
  end

  // TX state, counters and registered line driver.
  always_ff @(posedge user_clock or negedge rst) begin
    if (!rst) begin
      tx_state_r <= IDLE;
      tx_cnt_r   <= CNT_ZERO;
      tx_idx_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      txd_r      <= LINE_IDLE;
    end else begin
      tx_state_r <= tx_state_nxt_s;
      tx_cnt_r   <= tx_cnt_nxt_s;
      tx_idx_r   <= tx_idx_nxt_s;
      tx_shift_r <= tx_shift_nxt_s;
      txd_r      <= txd_line_s;
    end
  end

  // Receive activity indicator: toggle once per valid byte.
  always_ff @(posedge user_clock or negedge rst) begin
    if (!rst) begin
      led_r <= 1'b0;
    end else begin
      led_r <= led_r ^ rx_valid_s;
    end
  end

  assign usb_rs232_txd = txd_r;
  assign gpio_led1     = led_r;

endmodule

// File: tb/tb_uart_main.sv
// -----------------------------------------------------------------------------
// tb_uart_main
// Directed self-checking bench for uart_main (default build, echo disabled).
// TX frames are checked at the first, middle and last clock of every bit so the
// exact bit period is verified; RX frames are driven bit-by-bit from the bench.
// -----------------------------------------------------------------------------
module tb_uart_main;

  localparam int CPB = 434;

  logic       user_clock    = 1'b0;
  logic       rst           = 1'b0;
  logic       usb_rs232_rxd = 1'b1;
  logic       send_trigger  = 1'b0;
  logic [7:0] send_data     = 8'h00;
  logic       usb_rs232_txd;
  logic       gpio_led1;

  int tests_run    = 0;
  int tests_failed = 0;

  always #10 user_clock = ~user_clock;

  uart_main #(
    .CLK_FREQ_HZ(50000000),
    .BAUD       (115200)
  ) dut (
    .user_clock    (user_clock),
    .rst           (rst),
    .usb_rs232_rxd (usb_rs232_rxd),
    .send_trigger  (send_trigger),
    .send_data     (send_data),
    .usb_rs232_txd (usb_rs232_txd),
    .gpio_led1     (gpio_led1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clocks, landing 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge user_clock);
      #1;
    end
  endtask

  // Count edges until txd goes low (bounded).
  task automatic wait_fall(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      step(1);
      n++;
      if (usb_rs232_txd === 1'b0) ok = 1'b1;
    end
  endtask

  // Called on the first clock of the start bit; samples each bit three times.
  task automatic check_frame(input logic [7:0] d, input string tag);
    logic [9:0] exp_bits;
    logic [9:0] first_b;
    logic [9:0] mid_b;
    logic [9:0] last_b;
    exp_bits = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      first_b[i] = usb_rs232_txd;
      step(CPB / 2);
      mid_b[i] = usb_rs232_txd;
      step(CPB - 1 - CPB / 2);
      last_b[i] = usb_rs232_txd;
      if (i < 9) step(1);
    end
    check_eq({tag, "_first"}, 32'(first_b), 32'(exp_bits));
    check_eq({tag, "_mid"},   32'(mid_b),   32'(exp_bits));
    check_eq({tag, "_last"},  32'(last_b),  32'(exp_bits));
  endtask

  task automatic check_idle(input int n, input string tag);
    bit seen_low;
    seen_low = 1'b0;
    repeat (n) begin
      step(1);
      if (usb_rs232_txd !== 1'b1) seen_low = 1'b1;
    end
    check_eq(tag, 32'(seen_low), 32'd0);
  endtask

  // Trigger a frame holding send_trigger for 'hold' clocks; check latency,
  // the frame itself and 'idle_n' clocks of idle line afterwards.
  task automatic send_frame(input logic [7:0] d, input int hold, input int idle_n, input string tag);
    int lat;
    bit ok;
    @(negedge user_clock);
    send_data    = d;
    send_trigger = 1'b1;
    fork
      begin
        repeat (hold) @(negedge user_clock);
        send_trigger = 1'b0;
      end
      begin
        wait_fall(lat, ok);
        check_eq({tag, "_lat"}, 32'(lat), 32'd3);
        if (ok) begin
          check_frame(d, tag);
          check_idle(idle_n, {tag, "_idle"});
        end
      end
    join
  endtask

  task automatic rx_drive(input logic [7:0] d, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge user_clock);
      usb_rs232_rxd = bits[i];
      repeat (CPB - 1) @(negedge user_clock);
    end
    @(negedge user_clock);
    usb_rs232_rxd = 1'b1;
    repeat (20) @(negedge user_clock);
  endtask

  initial begin
    repeat (90000) @(posedge user_clock);
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int  lat;
    bit  ok;
    bit  bad_txd;
    bit  bad_led;

    // Reset held: line idle, LED off.
    bad_txd = 1'b0;
    bad_led = 1'b0;
    repeat (5) begin
      step(1);
      if (usb_rs232_txd !== 1'b1) bad_txd = 1'b1;
      if (gpio_led1 !== 1'b0) bad_led = 1'b1;
    end
    check_eq("reset_txd", 32'(bad_txd), 32'd0);
    check_eq("reset_led", 32'(bad_led), 32'd0);
    @(negedge user_clock);
    rst = 1'b1;
    check_idle(200, "post_reset_idle");
    check_eq("post_reset_led", 32'(gpio_led1), 32'd0);

    // Single 'A', exactly one frame.
    send_frame(8'h41, 40, 2 * CPB, "single_A");

    // 'A','L','E','X' sequence.
    send_frame(8'h41, 40, 150, "seq_A");
    send_frame(8'h4C, 40, 150, "seq_L");
    send_frame(8'h45, 40, 150, "seq_E");
    send_frame(8'h58, 40, 150, "seq_X");

    // Trigger held beyond the frame end: still one frame.
    send_frame(8'h96, 5000, 600, "held");

    // Edge during a frame with new data is ignored and not queued.
    @(negedge user_clock);
    send_data    = 8'hC3;
    send_trigger = 1'b1;
    fork
      begin
        repeat (40) @(negedge user_clock);
        send_trigger = 1'b0;
        repeat (960) @(negedge user_clock);
        send_data    = 8'h55;
        send_trigger = 1'b1;
        repeat (40) @(negedge user_clock);
        send_trigger = 1'b0;
      end
      begin
        wait_fall(lat, ok);
        check_eq("busy_lat", 32'(lat), 32'd3);
        check_frame(8'hC3, "busy");
        check_idle(2 * CPB, "busy_no_queue");
      end
    join

    // Receiver: good frame, framing error, glitch.
    rx_drive(8'h4C, 1'b1);
    check_eq("rx_data_4C", 32'(dut.rx_data_s), 32'h4C);
    check_eq("rx_led_on", 32'(gpio_led1), 32'd1);
    rx_drive(8'hA5, 1'b0);
    check_eq("rx_ferr_data", 32'(dut.rx_data_s), 32'h4C);
    check_eq("rx_ferr_led", 32'(gpio_led1), 32'd1);
    @(negedge user_clock);
    usb_rs232_rxd = 1'b0;
    repeat (100) @(negedge user_clock);
    usb_rs232_rxd = 1'b1;
    repeat (6 * CPB) @(negedge user_clock);
    check_eq("rx_glitch_data", 32'(dut.rx_data_s), 32'h4C);
    check_eq("rx_glitch_led", 32'(gpio_led1), 32'd1);

    // Reset in the middle of a TX frame.
    @(negedge user_clock);
    send_data    = 8'h41;
    send_trigger = 1'b1;
    fork
      begin
        repeat (40) @(negedge user_clock);
        send_trigger = 1'b0;
      end
      begin
        wait_fall(lat, ok);
        check_eq("midtx_lat", 32'(lat), 32'd3);
        step(5 * CPB + CPB / 2);
        check_eq("midtx_pre_txd", 32'(usb_rs232_txd), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("midtx_rst_txd", 32'(usb_rs232_txd), 32'd1);
        check_eq("midtx_rst_led", 32'(gpio_led1), 32'd0);
      end
    join
    bad_txd = 1'b0;
    repeat (3) begin
      step(1);
      if (usb_rs232_txd !== 1'b1) bad_txd = 1'b1;
    end
    check_eq("midtx_hold_txd", 32'(bad_txd), 32'd0);
    @(negedge user_clock);
    rst = 1'b1;

    // Full duplex after reset: transmit and receive at the same time.
    fork
      send_frame(8'h3C, 40, 150, "after_reset");
      rx_drive(8'hB2, 1'b1);
    join
    check_eq("duplex_rx_data", 32'(dut.rx_data_s), 32'hB2);
    check_eq("duplex_led", 32'(gpio_led1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_main.md
Name: uart_main

Overview:
- Top-level 8N1 UART for the board's USB-RS232 bridge.
- A pulse or level on send_trigger transmits the byte on send_data over usb_rs232_txd.
- The receiver deserialises bytes arriving on usb_rs232_rxd; gpio_led1 toggles on every valid received byte, giving a visible link indicator.
- Runs entirely in the user_clock domain (50 MHz nominal).

Parameters:
- CLK_FREQ_HZ, 50000000, user_clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD (integer truncation, 434), clocks per bit; derived, not overridden independently.

Ports:
- user_clock  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- usb_rs232_rxd  in  1  serial receive line, idle high; asynchronous to user_clock.
- send_trigger  in  1  transmit request; rising edge starts a frame.
- send_data  in  8  byte to transmit; sampled on the trigger edge.
- usb_rs232_txd  out  1  serial transmit line, idle high.
- gpio_led1  out  1  receive activity indicator.

Behaviour:
- Reset (rst=0, async):
  - usb_rs232_txd=1, gpio_led1=0, both FSMs IDLE, all counters 0.
  - Synchroniser and edge-detect flops set to 1 (rxd) and 0 (trigger).
  - Reset mid-frame aborts the frame immediately; txd is high while rst=0.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. Each bit lasts exactly CLKS_PER_BIT clocks; a frame is 10*CLKS_PER_BIT clocks.
- Trigger handling:
  - send_trigger is registered once.
  - A rising edge (prev=0, now=1) while TX is IDLE latches send_data into the shift register and enters START on the next clock. txd falls 2 clocks after the trigger is sampled high.
  - Holding trigger high for any duration sends exactly one frame; a new frame needs a new 0->1 edge.
  - An edge seen while TX is not IDLE is ignored and not queued.
  - send_data changes after latch do not affect the frame in flight.
- TX FSM: IDLE -> START -> DATA (bit index 0..7) -> STOP -> IDLE.
  - Bit counter resets to 0 at each bit boundary.
  - After STOP completes, TX is IDLE and accepts an edge on the very next clock (back-to-back capable).
- RX path:
  - usb_rs232_rxd passes through a 2-flop synchroniser; a high-impedance or undriven line is treated as idle (1).
  - RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling level (synchronised 0) enters START.
  - START: at CLKS_PER_BIT/2, if the line is still 0, go to DATA; otherwise this is a glitch and the FSM returns to IDLE.
  - DATA: sample each bit at mid-bit (every CLKS_PER_BIT after start-centre), LSB first.
  - STOP: sample the stop bit at mid-bit. If 1, the byte is valid: toggle gpio_led1 and store the byte in an internal rx_data register. If 0, it is a framing error: discard, no toggle. Either way return to IDLE.
- TX and RX are fully independent (full duplex).

Optional Feature:
- UART_ECHO_EN
- Defined:
  - Each valid received byte is retransmitted on txd if TX is IDLE in the cycle the byte completes.
  - A send_trigger edge in the same cycle has priority, and the echo is dropped.
  - An echo arriving while TX is busy is dropped.
- Undefined: no echo path exists; TX is driven only by send_trigger.

Decomposition:
- Package uart_pkg holds the CLKS_PER_BIT calculation function, the 4-state FSM enum (IDLE/START/DATA/STOP) shared by TX and RX, and the idle line level constant.
- One sub-module, uart_rx (synchroniser, RX FSM, data/valid outputs), is instantiated in uart_main.
- The TX FSM and trigger edge detect stay in uart_main.

Test Plan:
- Reset: rst=0 for 100 ns -> txd=1 and gpio_led1=0 throughout; after release with no stimulus, txd stays 1.
- Single send: send_data=0x41 ('A'), trigger high 40 clocks -> txd sequence 0,1,0,0,0,0,0,1,0,1, each 434 clocks (8680 ns), total 86.8 us; exactly one frame despite the held trigger.
- Sequence: 'A','L','E','X' (0x41,0x4C,0x45,0x58), each trigger pulsed 40 clocks, 90 us apart -> four correct frames with idle-high gaps of about 3.2 us.
- Busy ignore: trigger edge 1000 clocks into a frame with send_data=0x55 -> current frame completes unchanged and no 0x55 frame follows.
- RX: drive rxd with a 0x4C frame at 434 clocks/bit -> rx_data=0x4C and gpio_led1 toggles 0->1; a second frame with stop bit 0 -> no toggle. A 100-clock low glitch -> no reception.
- Reset mid-TX: assert rst halfway through a frame -> txd=1 immediately; after release, a new trigger sends a complete, correct frame.
